// File: rtl/uart_scan_pkg.sv
// Shared types and helpers for the UART-to-scan bridge.
package uart_scan_pkg;

   typedef enum logic [1:0] {ScIdle, ScLow, ScHigh, ScResp} scan_state_e;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   localparam logic [3:0] RespHdr = 4'b0000;

   function automatic int unsigned baud_div(int unsigned clkrate, int unsigned baudrate);
      return clkrate / baudrate;
   endfunction

   // Step k of a command byte is {tms, tdi} = cmd[2k+1:2k].
   function automatic logic [1:0] step_pair(logic [7:0] cmd, logic [1:0] k);
      return cmd[{k, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/uart_scan_bridge_if.sv
// Pin bundle of the bridge: host UART, scan chain and status LEDs/flags.
interface uart_scan_bridge_if;
   logic rx;
   logic tdo;
   logic tx;
   logic tck;
   logic tms;
   logic tdi;
   logic link;
   logic blink;
   logic overflow;
   logic frame_err;

   modport master (
      input  rx, tdo,
      output tx, tck, tms, tdi, link, blink, overflow, frame_err
   );

   modport slave (
      output rx, tdo,
      input  tx, tck, tms, tdi, link, blink, overflow, frame_err
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, start-bit validation, mid-bit sampling, stop check.
module uart_rx
   import uart_scan_pkg::*;
#(
   parameter int unsigned BaudDiv = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       frame_err_o,
   output logic       start_o
);

   localparam int unsigned CntW = $clog2(BaudDiv);
   localparam logic [CntW-1:0] HalfLast = CntW'(BaudDiv / 2 - 1);
   localparam logic [CntW-1:0] FullLast = CntW'(BaudDiv - 1);

   rx_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            meta_q, sync_q, prev_q;
   logic            fall;

   assign fall   = prev_q & ~sync_q;
   assign byte_o = shift_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RxIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         meta_q  <= rx_i;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      bit_d       = bit_q;
      shift_d     = shift_q;
      start_o     = 1'b0;
      valid_o     = 1'b0;
      frame_err_o = 1'b0;
      unique case (state_q)
         RxIdle: begin
            cnt_d = '0;
            if (fall) state_d = RxStart;
         end
         RxStart: begin
            if (cnt_q == HalfLast) begin
               cnt_d = '0;
               if (!sync_q) begin
                  state_d = RxData;
                  bit_d   = '0;
                  start_o = 1'b1;
               end else begin
                  state_d = RxIdle;
               end
            end
         end
         RxData: begin
            if (cnt_q == FullLast) begin
               cnt_d   = '0;
               shift_d = {sync_q, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = RxStop;
            end
         end
         RxStop: begin
            if (cnt_q == FullLast) begin
               cnt_d   = '0;
               state_d = RxIdle;
               if (sync_q) valid_o = 1'b1;
               else        frame_err_o = 1'b1;
            end
         end
         default: state_d = RxIdle;
      endcase
   end

endmodule

// File: rtl/uart_scan_bridge.sv
// UART command bytes in, four TCK/TMS/TDI scan steps out, captured TDO returned over TX.
module uart_scan_bridge
   import uart_scan_pkg::*;
#(
   parameter int unsigned CLKRATE     = 12_000_000,
   parameter int unsigned BAUDRATE    = 115_200,
   parameter int unsigned TCK_DIV     = 4,
   parameter int unsigned BLINK_HZ    = 1,
   parameter int unsigned LINK_CYCLES = 1_200_000
) (
   input logic               clk,
   input logic               reset,
   uart_scan_bridge_if.master bus
);

   localparam int unsigned BaudDiv   = baud_div(CLKRATE, BAUDRATE);
   localparam int unsigned BaudW     = $clog2(BaudDiv);
   localparam int unsigned TckW      = $clog2(TCK_DIV);
   localparam int unsigned BlinkHalf = CLKRATE / (2 * BLINK_HZ);
   localparam int unsigned BlinkW    = $clog2(BlinkHalf);
   localparam int unsigned LinkW     = $clog2(LINK_CYCLES + 1);

   localparam logic [BaudW-1:0]  BaudLast  = BaudW'(BaudDiv - 1);
   localparam logic [TckW-1:0]   TckLast   = TckW'(TCK_DIV - 1);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BlinkHalf - 1);
   localparam logic [LinkW-1:0]  LinkLoad  = LinkW'(LINK_CYCLES);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_ferr, rx_start;

   uart_rx #(
      .BaudDiv (BaudDiv)
   ) u_rx (
      .clk         (clk),
      .reset       (reset),
      .rx_i        (bus.rx),
      .byte_o      (rx_byte),
      .valid_o     (rx_valid),
      .frame_err_o (rx_ferr),
      .start_o     (rx_start)
   );

   // Command FIFO, 2 entries.
   logic [7:0] fifo_q [2];
   logic       wr_ptr_q, rd_ptr_q;
   logic [1:0] fcnt_q;
   logic       fifo_empty, fifo_full, push_ok, scan_pop;

   assign fifo_empty = (fcnt_q == 2'd0);
   assign fifo_full  = (fcnt_q == 2'd2);
   assign push_ok    = rx_valid & (~fifo_full | scan_pop);

   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wr_ptr_q] <= rx_byte;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         fcnt_q   <= '0;
      end else begin
         if (push_ok)  wr_ptr_q <= ~wr_ptr_q;
         if (scan_pop) rd_ptr_q <= ~rd_ptr_q;
         if (push_ok && !scan_pop)      fcnt_q <= fcnt_q + 1'b1;
         else if (!push_ok && scan_pop) fcnt_q <= fcnt_q - 1'b1;
      end
   end

   // Scan FSM.
   scan_state_e     sc_state_q, sc_state_d;
   logic [7:0]      cmd_q, cmd_d;
   logic [1:0]      step_q, step_d;
   logic [TckW-1:0] div_q, div_d;
   logic [3:0]      cap_q, cap_d;
   logic            tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
   logic            tx_load, tx_busy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sc_state_q <= ScIdle;
         cmd_q      <= '0;
         step_q     <= '0;
         div_q      <= '0;
         cap_q      <= '0;
         tck_q      <= 1'b0;
         tms_q      <= 1'b1;
         tdi_q      <= 1'b0;
      end else begin
         sc_state_q <= sc_state_d;
         cmd_q      <= cmd_d;
         step_q     <= step_d;
         div_q      <= div_d;
         cap_q      <= cap_d;
         tck_q      <= tck_d;
         tms_q      <= tms_d;
         tdi_q      <= tdi_d;
      end
   end

   always_comb begin
      sc_state_d = sc_state_q;
      cmd_d      = cmd_q;
      step_d     = step_q;
      div_d      = div_q + 1'b1;
      cap_d      = cap_q;
      tck_d      = tck_q;
      tms_d      = tms_q;
      tdi_d      = tdi_q;
      scan_pop   = 1'b0;
      tx_load    = 1'b0;
      unique case (sc_state_q)
         ScIdle: begin
            div_d = '0;
            if (!fifo_empty) begin
               scan_pop       = 1'b1;
               cmd_d          = fifo_q[rd_ptr_q];
               {tms_d, tdi_d} = step_pair(fifo_q[rd_ptr_q], 2'd0);
               step_d         = '0;
               sc_state_d     = ScLow;
            end
         end
         ScLow: begin
            if (div_q == TckLast) begin
               div_d         = '0;
               tck_d         = 1'b1;
               cap_d[step_q] = bus.tdo;
               sc_state_d    = ScHigh;
            end
         end
         ScHigh: begin
            if (div_q == TckLast) begin
               div_d = '0;
               tck_d = 1'b0;
               if (step_q == 2'd3) begin
                  sc_state_d = ScResp;
               end else begin
                  step_d         = step_q + 1'b1;
                  {tms_d, tdi_d} = step_pair(cmd_q, step_q + 1'b1);
                  sc_state_d     = ScLow;
               end
            end
         end
         ScResp: begin
            div_d = '0;
            if (!tx_busy_q) begin
               tx_load    = 1'b1;
               sc_state_d = ScIdle;
            end
         end
         default: sc_state_d = ScIdle;
      endcase
   end

   // TX: start bit is driven on load; the shifter holds data then stop.
   logic [BaudW-1:0] tx_cnt_q, tx_cnt_d;
   logic [8:0]       tx_sh_q, tx_sh_d;
   logic [3:0]       tx_bits_q, tx_bits_d;
   logic             tx_busy_d, tx_out_q, tx_out_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_cnt_q  <= '0;
         tx_sh_q   <= '1;
         tx_bits_q <= '0;
         tx_busy_q <= 1'b0;
         tx_out_q  <= 1'b1;
      end else begin
         tx_cnt_q  <= tx_cnt_d;
         tx_sh_q   <= tx_sh_d;
         tx_bits_q <= tx_bits_d;
         tx_busy_q <= tx_busy_d;
         tx_out_q  <= tx_out_d;
      end
   end

   always_comb begin
      tx_cnt_d  = tx_cnt_q + 1'b1;
      tx_sh_d   = tx_sh_q;
      tx_bits_d = tx_bits_q;
      tx_busy_d = tx_busy_q;
      tx_out_d  = tx_out_q;
      if (!tx_busy_q) begin
         tx_cnt_d = '0;
         if (tx_load) begin
            tx_busy_d = 1'b1;
            tx_out_d  = 1'b0;
            tx_sh_d   = {1'b1, RespHdr, cap_q};
            tx_bits_d = '0;
         end
      end else if (tx_cnt_q == BaudLast) begin
         tx_cnt_d = '0;
         if (tx_bits_q == 4'd9) begin
            tx_busy_d = 1'b0;
         end else begin
            tx_out_d  = tx_sh_q[0];
            tx_sh_d   = {1'b1, tx_sh_q[8:1]};
            tx_bits_d = tx_bits_q + 1'b1;
         end
      end
   end

   // Link hold, heartbeat and sticky error flags.
   logic [LinkW-1:0]  link_cnt_q;
   logic [BlinkW-1:0] blink_cnt_q;
   logic              blink_q, overflow_q, frame_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         link_cnt_q  <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (rx_start)                link_cnt_q <= LinkLoad;
         else if (link_cnt_q != '0)   link_cnt_q <= link_cnt_q - 1'b1;
         if (blink_cnt_q == BlinkLast) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
         if (rx_valid && fifo_full && !scan_pop) overflow_q <= 1'b1;
         if (rx_ferr) frame_err_q <= 1'b1;
      end
   end

   assign bus.tx        = tx_out_q;
   assign bus.tck       = tck_q;
   assign bus.tms       = tms_q;
   assign bus.tdi       = tdi_q;
   assign bus.link      = (link_cnt_q != '0);
   assign bus.blink     = blink_q;
   assign bus.overflow  = overflow_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_scan_bridge.sv
// Scoreboard bench: dut_a runs at defaults, dut_b uses slow steps to back up the FIFO.
`timescale 1ns/1ps
module tb_uart_scan_bridge;

   localparam int Bit = 104;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx_a = 1'b1;
   logic rx_b = 1'b1;
   logic tdo_mode = 1'b0;

   always #5 clk = ~clk;

   uart_scan_bridge_if bus_a ();
   uart_scan_bridge_if bus_b ();

   assign bus_a.rx  = rx_a;
   assign bus_a.tdo = tdo_mode ? bus_a.tdi : 1'b1;
   assign bus_b.rx  = rx_b;
   assign bus_b.tdo = bus_b.tdi;

   uart_scan_bridge dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   uart_scan_bridge #(
      .TCK_DIV (500)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   wire [1:0] txs = {bus_b.tx, bus_a.tx};

   int n_tests = 0;
   int n_fail  = 0;
   int got_cnt [2] = '{0, 0};
   logic [8:0] exp_q [$];
   logic [1:0] step_log [$];
   int         rise_log [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   always @(posedge bus_a.tck) begin
      step_log.push_back({bus_a.tms, bus_a.tdi});
      rise_log.push_back(int'($time / 10));
   end

   task automatic monitor(input int u);
      logic [7:0] b;
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (txs[u] == 1'b0) begin
            repeat (Bit / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (Bit) @(negedge clk);
               b[i] = txs[u];
            end
            repeat (Bit) @(negedge clk);
            check($sformatf("tx%0d stop", u), 32'(txs[u]), 32'd1);
            got_cnt[u]++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL tx%0d unexpected byte: got %02h, required none", u, b);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("tx%0d resp", u), 32'({u[0], b}), 32'(e));
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   task automatic drive(input int u, input logic v);
      if (u == 0) rx_a = v;
      else        rx_b = v;
   endtask

   task automatic send(input int u, input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(u, f[i]);
         repeat (Bit) @(negedge clk);
      end
      drive(u, 1'b1);
   endtask

   task automatic check_steps(input logic [7:0] cmd);
      logic [1:0] want;
      check("step count", 32'(step_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < step_log.size(); i++) begin
         want = cmd[2*i +: 2];
         check($sformatf("step%0d tms_tdi", i), 32'(step_log[i]), 32'(want));
         if (i > 0)
            check($sformatf("tck period %0d", i), 32'(rise_log[i] - rise_log[i-1]), 32'd8);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst tx", 32'(bus_a.tx), 32'd1);
      check("rst tck", 32'(bus_a.tck), 32'd0);
      check("rst tms", 32'(bus_a.tms), 32'd1);
      check("rst tdi", 32'(bus_a.tdi), 32'd0);
      check("rst link", 32'(bus_a.link), 32'd0);
      check("rst blink", 32'(bus_a.blink), 32'd0);
      check("rst overflow", 32'(bus_a.overflow), 32'd0);
      check("rst frame_err", 32'(bus_a.frame_err), 32'd0);

      // Glitch shorter than half a bit is a false start.
      rx_a = 1'b0;
      repeat (20) @(negedge clk);
      rx_a = 1'b1;
      repeat (300) @(negedge clk);
      check("glitch link", 32'(bus_a.link), 32'd0);
      check("glitch tck", 32'(step_log.size()), 32'd0);

      // 0x1B: pairs 11,10,01,00; tdo tied high -> 0x0F.
      exp_q.push_back({1'b0, 8'h0F});
      send(0, 8'h1B, 1'b1);
      repeat (1300) @(negedge clk);
      check("link after byte", 32'(bus_a.link), 32'd1);
      check_steps(8'h1B);
      check("resp count 1B", 32'(got_cnt[0]), 32'd1);

      // 0x44 with tdo=tdi: tdi per step 0,1,0,1 -> cap 4'b1010.
      tdo_mode = 1'b1;
      step_log.delete();
      rise_log.delete();
      exp_q.push_back({1'b0, 8'h0A});
      send(0, 8'h44, 1'b1);
      repeat (1300) @(negedge clk);
      check_steps(8'h44);
      check("resp count 44", 32'(got_cnt[0]), 32'd2);

      // Stop bit low: dropped, flagged, nothing executed.
      step_log.delete();
      rise_log.delete();
      send(0, 8'h55, 1'b0);
      repeat (1300) @(negedge clk);
      check("frame_err set", 32'(bus_a.frame_err), 32'd1);
      check("ferr no tck", 32'(step_log.size()), 32'd0);
      check("ferr no resp", 32'(got_cnt[0]), 32'd2);
      check("ferr no overflow", 32'(bus_a.overflow), 32'd0);

      // Slow steps: byte 1 executing, bytes 2-3 fill the FIFO, byte 4 dropped.
      exp_q.push_back({1'b1, 8'h01});
      exp_q.push_back({1'b1, 8'h02});
      exp_q.push_back({1'b1, 8'h04});
      send(1, 8'h01, 1'b1);
      send(1, 8'h04, 1'b1);
      send(1, 8'h10, 1'b1);
      send(1, 8'h40, 1'b1);
      check("overflow set", 32'(bus_b.overflow), 32'd1);
      repeat (11000) @(negedge clk);
      check("ovf resp count", 32'(got_cnt[1]), 32'd3);
      check("ovf frame_err", 32'(bus_b.frame_err), 32'd0);
      check("overflow sticky", 32'(bus_b.overflow), 32'd1);

      // Reset while tck is high.
      tdo_mode = 1'b0;
      step_log.delete();
      rise_log.delete();
      fork
         send(0, 8'hA5, 1'b1);
         begin
            for (int i = 0; i < 1500 && bus_a.tck !== 1'b1; i++) @(negedge clk);
            check("rst wait tck", 32'(bus_a.tck), 32'd1);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("midstep tck", 32'(bus_a.tck), 32'd0);
            check("midstep tms", 32'(bus_a.tms), 32'd1);
            check("midstep tx", 32'(bus_a.tx), 32'd1);
            check("midstep frame_err", 32'(bus_a.frame_err), 32'd0);
            check("midstep overflow b", 32'(bus_b.overflow), 32'd0);
         end
      join
      repeat (1300) @(negedge clk);
      check("no resp after reset", 32'(got_cnt[0]), 32'd2);

      // 0x3C with tdo=tdi: tdi per step 0,1,1,0 -> 0x06.
      tdo_mode = 1'b1;
      step_log.delete();
      rise_log.delete();
      exp_q.push_back({1'b0, 8'h06});
      send(0, 8'h3C, 1'b1);
      repeat (1300) @(negedge clk);
      check_steps(8'h3C);
      check("resp count 3C", 32'(got_cnt[0]), 32'd3);
      check("scoreboard empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
